// File: rtl/i2c_reg_xfer_seq.sv
// I2C register transfer sequencer: drives a byte controller through
// register write (addr+reg+data) and register read (addr+reg+restart+data).
module i2c_reg_xfer_seq #(
  parameter int unsigned NACK_RETRIES = 2
) (
  input  logic       clk,
  input  logic       nReset,
  input  logic       req,
  input  logic       req_rnw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       err_nack,
  output logic       err_al,
  output logic       bc_start,
  output logic       bc_stop,
  output logic       bc_read,
  output logic       bc_write,
  output logic       bc_ack_in,
  output logic [7:0] bc_din,
  input  logic       bc_cmd_ack,
  input  logic       bc_ack_out,
  input  logic [7:0] bc_dout,
  input  logic       bc_al
);

  typedef enum logic [2:0] {IDLE, DEVW, REGA, WDAT, RSTRT, RDAT, STOP, DONE} state_e;

  typedef struct packed {
    logic       start;
    logic       stop;
    logic       read;
    logic       write;
    logic       ack_in;
    logic [7:0] din;
  } bc_cmd_t;

  state_e     state_q, state_d;
  bc_cmd_t    cmd_q, cmd_d;
  logic       rnw_q, rnw_d;
  logic [6:0] dev_q, dev_d;
  logic [7:0] reg_q, reg_d;
  logic [7:0] wdat_q, wdat_d;
  logic [2:0] retry_q, retry_d;
  logic       nack_devw_q, nack_devw_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] rdata_q, rdata_d;
  logic       err_nack_q, err_nack_d;
  logic       err_al_q, err_al_d;

  // Command issued on entry to each command state; non-command states yield all zeros.
  function automatic bc_cmd_t cmd_of(input state_e s, input logic [6:0] dev,
                                     input logic [7:0] ra, input logic [7:0] wd);
    bc_cmd_t c;
    c = '0;
    unique case (s)
      DEVW:  begin c.start = 1'b1; c.write = 1'b1; c.din = {dev, 1'b0}; end
      REGA:  begin c.write = 1'b1; c.din = ra; end
      WDAT:  begin c.write = 1'b1; c.stop = 1'b1; c.din = wd; end
      RSTRT: begin c.start = 1'b1; c.write = 1'b1; c.din = {dev, 1'b1}; end
      RDAT:  begin c.read = 1'b1; c.stop = 1'b1; c.ack_in = 1'b1; end
      STOP:  c.stop = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    // NOTE: every _d gets a default before the case so no path infers a latch.
    state_d     = state_q;
    cmd_d       = cmd_q;
    rnw_d       = rnw_q;
    dev_d       = dev_q;
    reg_d       = reg_q;
    wdat_d      = wdat_q;
    retry_d     = retry_q;
    nack_devw_d = nack_devw_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rdata_d     = rdata_q;
    err_nack_d  = err_nack_q;
    err_al_d    = err_al_q;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          rnw_d      = req_rnw;
          dev_d      = dev_addr;
          reg_d      = reg_addr;
          wdat_d     = wdata;
          retry_d    = 3'(NACK_RETRIES);
          busy_d     = 1'b1;
          err_nack_d = 1'b0;
          err_al_d   = 1'b0;
          state_d    = DEVW;
          cmd_d      = cmd_of(DEVW, dev_addr, reg_addr, wdata);
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        // Arbitration loss wins over a simultaneous command completion; the bus is not ours, so no stop.
        if (bc_al) begin
          cmd_d      = '0;
          err_al_d   = 1'b1;
          err_nack_d = 1'b0;
          state_d    = DONE;
        end else if (bc_cmd_ack) begin
          cmd_d = '0;
          unique case (state_q)
            DEVW: begin
              nack_devw_d = bc_ack_out;
              state_d     = bc_ack_out ? STOP : REGA;
            end
            REGA: begin
              nack_devw_d = 1'b0;
              state_d     = bc_ack_out ? STOP : (rnw_q ? RSTRT : WDAT);
            end
            WDAT: begin
              err_nack_d = bc_ack_out;
              state_d    = DONE;
            end
            RSTRT: begin
              nack_devw_d = 1'b0;
              state_d     = bc_ack_out ? STOP : RDAT;
            end
            RDAT: begin
              rdata_d = bc_dout;
              state_d = DONE;
            end
            STOP: begin
              if (nack_devw_q && retry_q != 3'd0) begin
                retry_d = retry_q - 3'd1;
                state_d = DEVW;
              end else begin
                err_nack_d = 1'b1;
                state_d    = DONE;
              end
            end
            default: state_d = DONE;
          endcase
          cmd_d = cmd_of(state_d, dev_q, reg_q, wdat_q);
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      rnw_q       <= 1'b0;
      dev_q       <= '0;
      reg_q       <= '0;
      wdat_q      <= '0;
      retry_q     <= '0;
      nack_devw_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rdata_q     <= '0;
      err_nack_q  <= 1'b0;
      err_al_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      rnw_q       <= rnw_d;
      dev_q       <= dev_d;
      reg_q       <= reg_d;
      wdat_q      <= wdat_d;
      retry_q     <= retry_d;
      nack_devw_q <= nack_devw_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      err_nack_q  <= err_nack_d;
      err_al_q    <= err_al_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign err_nack  = err_nack_q;
  assign err_al    = err_al_q;
  assign bc_start  = cmd_q.start;
  assign bc_stop   = cmd_q.stop;
  assign bc_read   = cmd_q.read;
  assign bc_write  = cmd_q.write;
  assign bc_ack_in = cmd_q.ack_in;
  assign bc_din    = cmd_q.din;

endmodule

// File: tb/tb_i2c_reg_xfer_seq.sv
// Directed bench for i2c_reg_xfer_seq: a scripted byte-controller model
// checks each issued command against a queue of expected commands.
module tb_i2c_reg_xfer_seq;

  logic       clk = 1'b0;
  logic       nReset;
  logic       req, req_rnw;
  logic [6:0] dev_addr;
  logic [7:0] reg_addr, wdata;
  logic       busy, done, err_nack, err_al;
  logic [7:0] rdata;
  logic       bc_start, bc_stop, bc_read, bc_write, bc_ack_in;
  logic [7:0] bc_din;
  logic       bc_cmd_ack, bc_ack_out, bc_al;
  logic [7:0] bc_dout;

  int checks = 0;
  int errors = 0;
  logic [12:0] exp_q[$];

  i2c_reg_xfer_seq #(.NACK_RETRIES(2)) dut (
    .clk(clk), .nReset(nReset), .req(req), .req_rnw(req_rnw),
    .dev_addr(dev_addr), .reg_addr(reg_addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .err_nack(err_nack), .err_al(err_al),
    .bc_start(bc_start), .bc_stop(bc_stop), .bc_read(bc_read), .bc_write(bc_write),
    .bc_ack_in(bc_ack_in), .bc_din(bc_din), .bc_cmd_ack(bc_cmd_ack),
    .bc_ack_out(bc_ack_out), .bc_dout(bc_dout), .bc_al(bc_al)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] mk(input logic st, input logic sp, input logic rd,
                                     input logic wr, input logic ai, input logic [7:0] d);
    return {st, sp, rd, wr, ai, d};
  endfunction

  function automatic logic [12:0] cur_cmd();
    return {bc_start, bc_stop, bc_read, bc_write, bc_ack_in, bc_din};
  endfunction

  function automatic logic [24:0] all_outs();
    return {busy, done, rdata, err_nack, err_al, cur_cmd()};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input logic rnw, input logic [6:0] dv, input logic [7:0] ra,
                           input logic [7:0] wd);
    req = 1'b1; req_rnw = rnw; dev_addr = dv; reg_addr = ra; wdata = wd;
    @(negedge clk);
    req = 1'b0;
  endtask

  // Waits for a command, scores it, checks it is held, then completes it.
  task automatic serve(input string tag, input logic ack, input logic ack_out,
                       input logic [7:0] dout, input logic al);
    logic [12:0] exp;
    int n = 0;
    while (cur_cmd()[12:9] == 4'b0000 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() == 0) exp = '0;
    else exp = exp_q.pop_front();
    chk({tag, "_cmd"}, 32'(cur_cmd()), 32'(exp));
    repeat (2) @(negedge clk);
    chk({tag, "_hold"}, 32'(cur_cmd()), 32'(exp));
    bc_cmd_ack = ack; bc_ack_out = ack_out; bc_dout = dout; bc_al = al;
    @(negedge clk);
    bc_cmd_ack = 1'b0; bc_ack_out = 1'b0; bc_dout = 8'h00; bc_al = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic en, input logic ea,
                           input logic [7:0] erd);
    int n = 0;
    while (done !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
    chk({tag, "_status"}, {21'd0, busy, err_nack, err_al, rdata}, {21'd0, 1'b0, en, ea, erd});
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    nReset = 1'b0; req = 1'b0; req_rnw = 1'b0; dev_addr = '0; reg_addr = '0; wdata = '0;
    bc_cmd_ack = 1'b0; bc_ack_out = 1'b0; bc_dout = '0; bc_al = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'(all_outs()), 32'd0);
    nReset = 1'b1;
    @(negedge clk);

    // Register write, all ACK.
    exp_q.push_back(mk(1, 0, 0, 1, 0, 8'hA0));
    exp_q.push_back(mk(0, 0, 0, 1, 0, 8'h10));
    exp_q.push_back(mk(0, 1, 0, 1, 0, 8'hA5));
    start_req(1'b0, 7'h50, 8'h10, 8'hA5);
    chk("wr_busy", 32'(busy), 32'd1);
    serve("wr_devw", 1, 0, 8'h00, 0);
    serve("wr_rega", 1, 0, 8'h00, 0);
    serve("wr_wdat", 1, 0, 8'h00, 0);
    chk("wr_bc_clear", 32'(cur_cmd()), 32'd0);
    wait_done("wr", 0, 0, 8'h00);

    // Register read returning 3C.
    exp_q.push_back(mk(1, 0, 0, 1, 0, 8'hA0));
    exp_q.push_back(mk(0, 0, 0, 1, 0, 8'h22));
    exp_q.push_back(mk(1, 0, 0, 1, 0, 8'hA1));
    exp_q.push_back(mk(0, 1, 1, 0, 1, 8'h00));
    start_req(1'b1, 7'h50, 8'h22, 8'h00);
    serve("rd_devw", 1, 0, 8'h00, 0);
    serve("rd_rega", 1, 0, 8'h00, 0);
    serve("rd_rstrt", 1, 0, 8'h00, 0);
    serve("rd_rdat", 1, 1, 8'h3C, 0);
    wait_done("rd", 0, 0, 8'h3C);

    // Device NACK on all three attempts.
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk(1, 0, 0, 1, 0, 8'hA0));
      exp_q.push_back(mk(0, 1, 0, 0, 0, 8'h00));
    end
    start_req(1'b0, 7'h50, 8'h33, 8'h44);
    for (int i = 0; i < 3; i++) begin
      serve("nk_devw", 1, 1, 8'h00, 0);
      serve("nk_stop", 1, 0, 8'h00, 0);
    end
    wait_done("nk", 1, 0, 8'h3C);

    // Arbitration lost during REGA.
    exp_q.push_back(mk(1, 0, 0, 1, 0, 8'hA0));
    exp_q.push_back(mk(0, 0, 0, 1, 0, 8'h10));
    start_req(1'b0, 7'h50, 8'h10, 8'h01);
    serve("al_devw", 1, 0, 8'h00, 0);
    serve("al_rega", 0, 0, 8'h00, 1);
    chk("al_bc_zero", {18'd0, done, cur_cmd()}, 32'd0);
    @(negedge clk);
    chk("al_done", {29'd0, done, err_al, err_nack}, {29'd0, 3'b110});
    @(negedge clk);

    // New write after arbitration loss; error flags clear.
    exp_q.push_back(mk(1, 0, 0, 1, 0, 8'hA2));
    exp_q.push_back(mk(0, 0, 0, 1, 0, 8'h05));
    exp_q.push_back(mk(0, 1, 0, 1, 0, 8'h77));
    start_req(1'b0, 7'h51, 8'h05, 8'h77);
    chk("post_al_errs", {30'd0, err_al, err_nack}, 32'd0);
    serve("pa_devw", 1, 0, 8'h00, 0);
    serve("pa_rega", 1, 0, 8'h00, 0);
    serve("pa_wdat", 1, 0, 8'h00, 0);
    wait_done("pa", 0, 0, 8'h3C);

    // Reset during RDAT.
    exp_q.push_back(mk(1, 0, 0, 1, 0, 8'hA0));
    exp_q.push_back(mk(0, 0, 0, 1, 0, 8'h22));
    exp_q.push_back(mk(1, 0, 0, 1, 0, 8'hA1));
    start_req(1'b1, 7'h50, 8'h22, 8'h00);
    serve("rs_devw", 1, 0, 8'h00, 0);
    serve("rs_rega", 1, 0, 8'h00, 0);
    serve("rs_rstrt", 1, 0, 8'h00, 0);
    chk("rs_in_rdat", 32'(cur_cmd()), 32'(mk(0, 1, 1, 0, 1, 8'h00)));
    nReset = 1'b0;
    @(negedge clk);
    chk("rs_outs", 32'(all_outs()), 32'd0);
    nReset = 1'b1;
    @(negedge clk);
    exp_q.push_back(mk(1, 0, 0, 1, 0, 8'hA0));
    exp_q.push_back(mk(0, 0, 0, 1, 0, 8'h11));
    exp_q.push_back(mk(0, 1, 0, 1, 0, 8'h5A));
    start_req(1'b0, 7'h50, 8'h11, 8'h5A);
    serve("rw_devw", 1, 0, 8'h00, 0);
    serve("rw_rega", 1, 0, 8'h00, 0);
    serve("rw_wdat", 1, 0, 8'h00, 0);
    wait_done("rw", 0, 0, 8'h00);

    // req held while busy; ack and al together in REGA.
    exp_q.push_back(mk(1, 0, 0, 1, 0, 8'hA0));
    exp_q.push_back(mk(0, 0, 0, 1, 0, 8'h10));
    req = 1'b1; req_rnw = 1'b0; dev_addr = 7'h50; reg_addr = 8'h10; wdata = 8'h99;
    @(negedge clk);
    serve("hq_devw", 1, 0, 8'h00, 0);
    serve("hq_rega", 1, 0, 8'h00, 1);
    chk("hq_bc_zero", 32'(cur_cmd()), 32'd0);
    @(negedge clk);
    chk("hq_done", {29'd0, done, err_al, err_nack}, {29'd0, 3'b110});
    req = 1'b0;
    @(negedge clk);
    chk("hq_idle", {30'd0, busy, bc_start}, 32'd0);
    chk("hq_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
